// File: rtl/mu0_pkg.sv
// Shared opcode, ALU-function and state encodings for the MU0 control unit,
// plus the packed control vector that drives the datapath.
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALU_PASSY = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_INC   = 2'b10;
  localparam logic [1:0] ALU_SUB   = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  typedef struct packed {
    logic       ir_en;
    logic       pc_en;
    logic       acc_en;
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic [1:0] alu_fn;
    logic       rd;
    logic       wr;
    logic       fetch;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mu0_ctrl_decode.sv
// Combinational decode of (state, opcode, flags) into the datapath control vector.
// Zero latency; no flow control.
module mu0_ctrl_decode
  import mu0_pkg::*;
(
  input  logic [1:0] state,
  input  logic [3:0] f,
  input  logic       n,
  input  logic       z,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.addr_sel = 1'b0;
        ctrl.rd       = 1'b1;
        ctrl.ir_en    = 1'b1;
        ctrl.x_sel    = 1'b1;
        ctrl.alu_fn   = ALU_INC;
        ctrl.pc_en    = 1'b1;
        ctrl.fetch    = 1'b1;
      end
      ST_EXEC: begin
        case (f)
          OP_LDA: begin
            ctrl.addr_sel = 1'b1;
            ctrl.rd       = 1'b1;
            ctrl.alu_fn   = ALU_PASSY;
            ctrl.acc_en   = 1'b1;
          end
          OP_STA: begin
            ctrl.addr_sel = 1'b1;
            ctrl.wr       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.addr_sel = 1'b1;
            ctrl.rd       = 1'b1;
            ctrl.alu_fn   = (f == OP_ADD) ? ALU_ADD : ALU_SUB;
            ctrl.acc_en   = 1'b1;
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            ctrl.y_sel  = 1'b1;
            ctrl.alu_fn = ALU_PASSY;
            // Flags come straight from ACC, i.e. as left by the previous instruction
            ctrl.pc_en  = (f == OP_JMP) | ((f == OP_JGE) & ~n) | ((f == OP_JNE) & ~z);
          end
          default: ;
        endcase
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute control: state register, next-state logic and reset gating.
// Outputs are combinational from state/inputs; every non-halting instruction takes 2 cycles.
module mu0_control
  import mu0_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  output logic       IR_En,
  output logic       PC_En,
  output logic       Acc_En,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic [1:0] ALU_fn,
  output logic       Rd,
  output logic       Wr,
  output logic       Fetch,
  output logic       Halted
);

  state_t state;
  state_t state_d;
  ctrl_t  dec;
  ctrl_t  ctrl;

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_FETCH;
    else       state <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (F == OP_STP || (HALT_ON_ILLEGAL && F[3])) state_d = ST_HALT;
        else                                          state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  mu0_ctrl_decode u_decode (
    .state (state),
    .f     (F),
    .n     (N),
    .z     (Z),
    .ctrl  (dec)
  );

  // Gating here is what stops a half-executed instruction committing under reset
  assign ctrl = Reset ? '0 : dec;

  assign IR_En    = ctrl.ir_en;
  assign PC_En    = ctrl.pc_en;
  assign Acc_En   = ctrl.acc_en;
  assign X_sel    = ctrl.x_sel;
  assign Y_sel    = ctrl.y_sel;
  assign Addr_sel = ctrl.addr_sel;
  assign ALU_fn   = ctrl.alu_fn;
  assign Rd       = ctrl.rd;
  assign Wr       = ctrl.wr;
  assign Fetch    = ctrl.fetch;
  assign Halted   = ctrl.halted;

endmodule

// File: tb/tb_mu0_control.sv
// Scoreboard bench for mu0_control: one instance per HALT_ON_ILLEGAL setting,
// stimulus pushes hand-computed control vectors, a negedge monitor compares them.
module tb_mu0_control;

  logic       Clk;
  logic       Reset;
  logic [3:0] F;
  logic       N;
  logic       Z;

  logic       ir0, pc0, acc0, xs0, ys0, as0, rd0, wr0, fe0, ha0;
  logic [1:0] alu0;
  logic       ir1, pc1, acc1, xs1, ys1, as1, rd1, wr1, fe1, ha1;
  logic [1:0] alu1;

  int checks = 0;
  int errors = 0;

  logic [12:0] exp0_q[$];
  logic [12:0] exp1_q[$];
  string       name_q[$];

  mu0_control #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z),
    .IR_En(ir0), .PC_En(pc0), .Acc_En(acc0), .X_sel(xs0), .Y_sel(ys0),
    .Addr_sel(as0), .ALU_fn(alu0), .Rd(rd0), .Wr(wr0), .Fetch(fe0), .Halted(ha0)
  );

  mu0_control #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z),
    .IR_En(ir1), .PC_En(pc1), .Acc_En(acc1), .X_sel(xs1), .Y_sel(ys1),
    .Addr_sel(as1), .ALU_fn(alu1), .Rd(rd1), .Wr(wr1), .Fetch(fe1), .Halted(ha1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Vector order: IR_En PC_En Acc_En X_sel Y_sel Addr_sel ALU_fn[1:0] Rd Wr Fetch Halted
  function automatic logic [12:0] mk(input logic ir, pc, acc, xs, ys, as_,
                                     input logic [1:0] alu,
                                     input logic rd, wr, fe, ha);
    mk = {ir, pc, acc, xs, ys, as_, alu, rd, wr, fe, ha};
  endfunction

  logic [12:0] V_ZERO, V_FETCH, V_LDA, V_STA, V_ADD, V_SUB, V_JMP, V_JNO, V_HALT;

  initial begin
    V_ZERO  = mk(0,0,0,0,0,0,2'b00,0,0,0,0);
    V_FETCH = mk(1,1,0,1,0,0,2'b10,1,0,1,0);
    V_LDA   = mk(0,0,1,0,0,1,2'b00,1,0,0,0);
    V_STA   = mk(0,0,0,0,0,1,2'b00,0,1,0,0);
    V_ADD   = mk(0,0,1,0,0,1,2'b01,1,0,0,0);
    V_SUB   = mk(0,0,1,0,0,1,2'b11,1,0,0,0);
    V_JMP   = mk(0,1,0,0,1,0,2'b00,0,0,0,0);
    V_JNO   = mk(0,0,0,0,1,0,2'b00,0,0,0,0);
    V_HALT  = mk(0,0,0,0,0,0,2'b00,0,0,0,1);
  end

  task automatic step(input logic r, input logic [3:0] f, input logic n_i, input logic z_i,
                      input string nm, input logic [12:0] e0, input logic [12:0] e1);
    @(posedge Clk);
    #1;
    Reset = r;
    F     = f;
    N     = n_i;
    Z     = z_i;
    exp0_q.push_back(e0);
    exp1_q.push_back(e1);
    name_q.push_back(nm);
  endtask

  always @(negedge Clk) begin
    if (exp0_q.size() > 0) begin
      logic [12:0] e0, e1, a0, a1;
      string nm;
      e0 = exp0_q.pop_front();
      e1 = exp1_q.pop_front();
      nm = name_q.pop_front();
      a0 = {ir0, pc0, acc0, xs0, ys0, as0, alu0, rd0, wr0, fe0, ha0};
      a1 = {ir1, pc1, acc1, xs1, ys1, as1, alu1, rd1, wr1, fe1, ha1};
      checks++;
      if (a0 !== e0) begin
        errors++;
        $display("FAIL %s (halt_on_illegal=0): got %b expected %b", nm, a0, e0);
      end
      checks++;
      if (a1 !== e1) begin
        errors++;
        $display("FAIL %s (halt_on_illegal=1): got %b expected %b", nm, a1, e1);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    F     = 4'd0;
    N     = 1'b0;
    Z     = 1'b0;

    step(1, 4'd0, 0, 0, "reset0", V_ZERO, V_ZERO);
    step(1, 4'd0, 0, 0, "reset1", V_ZERO, V_ZERO);
    step(0, 4'd0, 0, 0, "fetch_after_reset", V_FETCH, V_FETCH);
    step(0, 4'd0, 0, 0, "lda", V_LDA, V_LDA);
    step(0, 4'd2, 0, 0, "fetch_a", V_FETCH, V_FETCH);
    step(0, 4'd2, 0, 0, "add", V_ADD, V_ADD);
    step(0, 4'd3, 0, 0, "fetch_s", V_FETCH, V_FETCH);
    step(0, 4'd3, 0, 0, "sub", V_SUB, V_SUB);
    step(0, 4'd1, 0, 0, "fetch_sta", V_FETCH, V_FETCH);
    step(0, 4'd1, 0, 0, "sta", V_STA, V_STA);
    step(0, 4'd1, 0, 0, "fetch_after_sta", V_FETCH, V_FETCH);
    step(0, 4'd5, 1, 0, "jge_neg", V_JNO, V_JNO);
    step(0, 4'd5, 0, 0, "fetch_jge", V_FETCH, V_FETCH);
    step(0, 4'd5, 0, 1, "jge_pos", V_JMP, V_JMP);
    step(0, 4'd6, 0, 1, "fetch_jne", V_FETCH, V_FETCH);
    step(0, 4'd6, 0, 1, "jne_zero", V_JNO, V_JNO);
    step(0, 4'd6, 1, 0, "fetch_jne2", V_FETCH, V_FETCH);
    step(0, 4'd6, 1, 0, "jne_nonzero", V_JMP, V_JMP);
    step(0, 4'd4, 1, 1, "fetch_jmp", V_FETCH, V_FETCH);
    step(0, 4'd4, 1, 1, "jmp", V_JMP, V_JMP);
    step(0, 4'hC, 0, 0, "fetch_illegal", V_FETCH, V_FETCH);
    step(0, 4'hC, 0, 0, "illegal_exec", V_ZERO, V_ZERO);
    step(0, 4'd0, 0, 0, "after_illegal", V_FETCH, V_HALT);
    step(0, 4'd0, 0, 0, "after_illegal2", V_LDA, V_HALT);
    // Reset partway through a STA must not let the write strobe out
    step(1, 4'd0, 0, 0, "reset_again", V_ZERO, V_ZERO);
    step(0, 4'd1, 0, 0, "fetch_sta_r", V_FETCH, V_FETCH);
    step(1, 4'd1, 0, 0, "sta_under_reset", V_ZERO, V_ZERO);
    step(0, 4'd7, 0, 0, "fetch_after_mid_reset", V_FETCH, V_FETCH);
    step(0, 4'd7, 0, 0, "stp_exec", V_ZERO, V_ZERO);
    for (int i = 0; i < 10; i++) begin
      step(0, 4'(i), i[0], i[1], "halt_hold", V_HALT, V_HALT);
    end
    step(1, 4'd7, 0, 0, "reset_from_halt", V_ZERO, V_ZERO);
    step(0, 4'd7, 0, 0, "fetch_after_halt", V_FETCH, V_FETCH);

    repeat (4) @(posedge Clk);
    if (exp0_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp0_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
